// File: rtl/switch_input_port.sv
// Memory-mapped switch input port: 2-flop sync, per-switch debounce, paged read mux.
// Optional sticky rising-edge flags with read-to-clear when SW_EDGE_CAPTURE_EN is defined.
module switch_input_port #(
  parameter int unsigned REG_WIDTH       = 8,
  parameter int unsigned ADDR_WIDTH      = 4,
  parameter int unsigned NUM_SW          = 9,
  parameter int unsigned SW_BASE_ADDR    = 12,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rd_en,
  input  logic [REG_WIDTH-1:0]  reg_data,
  input  logic [NUM_SW-1:0]     switches,
  output logic [REG_WIDTH-1:0]  reg_out
);

  localparam int unsigned NumPages = (NUM_SW + REG_WIDTH - 1) / REG_WIDTH;
  localparam int unsigned PadW     = NumPages * REG_WIDTH;
  localparam int unsigned CntW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  if (SW_BASE_ADDR + 2 * NumPages > 2 ** ADDR_WIDTH) begin : g_addr_err
    $error("switch_input_port: switch/edge pages exceed the address space");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_deb_err
    $error("switch_input_port: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [NUM_SW-1:0] sync1_q, sync2_q;
  logic [NUM_SW-1:0] stable_q, stable_d;
  logic [CntW-1:0]   cnt_q [NUM_SW];
  logic [CntW-1:0]   cnt_d [NUM_SW];
  logic [PadW-1:0]   stable_pad;

  always_comb begin
    for (int i = 0; i < int'(NUM_SW); i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < int'(NUM_SW); i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= switches;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < int'(NUM_SW); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign stable_pad = PadW'(stable_q);

`ifdef SW_EDGE_CAPTURE_EN
  logic [NUM_SW-1:0] edge_q, edge_set, edge_clr;
  logic [PadW-1:0]   edge_pad;

  always_comb begin
    edge_set = stable_d & ~stable_q;
    for (int i = 0; i < int'(NUM_SW); i++) begin
      edge_clr[i] = rd_en &&
        (addr == ADDR_WIDTH'(SW_BASE_ADDR + NumPages + i / int'(REG_WIDTH)));
    end
  end

  // Set wins over a same-cycle read-to-clear so no rising edge is lost.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      edge_q <= '0;
    end else begin
      edge_q <= (edge_q & ~edge_clr) | edge_set;
    end
  end

  assign edge_pad = PadW'(edge_q);
`else
  logic unused_rd_en;
  assign unused_rd_en = rd_en;
`endif

  always_comb begin
    reg_out = reg_data;
    for (int p = 0; p < int'(NumPages); p++) begin
      if (addr == ADDR_WIDTH'(SW_BASE_ADDR + p)) begin
        reg_out = stable_pad[p*REG_WIDTH +: REG_WIDTH];
      end
`ifdef SW_EDGE_CAPTURE_EN
      if (addr == ADDR_WIDTH'(SW_BASE_ADDR + NumPages + p)) begin
        reg_out = edge_pad[p*REG_WIDTH +: REG_WIDTH];
      end
`endif
    end
  end

endmodule

// File: tb/tb_switch_input_port.sv
// Self-checking bench for switch_input_port: expected read values are queued when
// stimulus is driven and compared when the output is sampled.
module tb_switch_input_port;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [3:0] addr;
  logic       rd_en;
  logic [7:0] reg_data;
  logic [8:0] switches;
  logic [7:0] reg_out;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  switch_input_port dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .addr     (addr),
    .rd_en    (rd_en),
    .reg_data (reg_data),
    .switches (switches),
    .reg_out  (reg_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 8'h%02h, expected 8'h%02h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, got 8'h%02h", tag, reg_out);
    end else begin
      check_eq(tag, reg_out, exp_q.pop_front());
    end
  endtask

  // Combinational read: drive address/data, queue expectation, sample shortly after.
  task automatic read_now(input string tag, input logic [3:0] a, input logic [7:0] d,
                          input logic [7:0] exp);
    addr     = a;
    reg_data = d;
    exp_q.push_back(exp);
    #1;
    pop_check(tag);
  endtask

  // Queue expectation for the value visible just after the next rising edge.
  task automatic step_expect(input string tag, input logic [7:0] exp);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  initial begin
    n_reset  = 1'b0;
    addr     = 4'd12;
    rd_en    = 1'b0;
    reg_data = 8'h00;
    switches = 9'h1A5;

    // 1: reset state, then 2+4 edge latency
    repeat (2) @(posedge clk);
    #1;
    read_now("rst_pg0", 4'd12, 8'h77, 8'h00);
    read_now("rst_pg1", 4'd13, 8'h77, 8'h00);
    addr = 4'd12;
    n_reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step_expect($sformatf("lat_e%0d", k), (k < 6) ? 8'h00 : 8'hA5);
    end
    read_now("pg1_1a5", 4'd13, 8'h00, 8'h01);

    // 2: page 1 zero-fill and pass-through
    switches = 9'h100;
    repeat (8) @(posedge clk);
    #1;
    read_now("pg1_100", 4'd13, 8'h00, 8'h01);
    read_now("pg0_100", 4'd12, 8'h00, 8'h00);
    read_now("pass_3", 4'd3, 8'h3C, 8'h3C);
    read_now("pass_0", 4'd0, 8'hA5, 8'hA5);

    // 3: short glitch rejected, long toggle accepted
    addr = 4'd12;
    switches = 9'h101;
    repeat (3) @(posedge clk);
    #1;
    switches = 9'h100;
    for (int k = 1; k <= 8; k++) step_expect($sformatf("glitch_e%0d", k), 8'h00);
    switches = 9'h101;
    for (int k = 1; k <= 6; k++) begin
      step_expect($sformatf("hold_e%0d", k), (k < 6) ? 8'h00 : 8'h01);
    end

    // 4: reset mid-debounce discards progress
    switches = 9'h0FF;
    repeat (3) @(posedge clk);
    #1;
    read_now("pre_rst", 4'd12, 8'h00, 8'h01);
    n_reset = 1'b0;
    read_now("async_rst", 4'd12, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step_expect($sformatf("rerun_e%0d", k), (k < 6) ? 8'h00 : 8'hFF);
    end
    read_now("pg1_0ff", 4'd13, 8'h00, 8'h00);

`ifdef SW_EDGE_CAPTURE_EN
    // 5: sticky flags with read-to-clear
    read_now("edge14_ff", 4'd14, 8'h00, 8'hFF);
    switches = 9'h1FF;
    repeat (6) @(posedge clk);
    #1;
    read_now("edge15_set", 4'd15, 8'h00, 8'h01);
    read_now("edge15_hold", 4'd15, 8'h00, 8'h01);
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    read_now("edge15_clr", 4'd15, 8'h00, 8'h00);
    read_now("edge14_kept", 4'd14, 8'h00, 8'hFF);
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    read_now("edge14_clr", 4'd14, 8'h00, 8'h00);

    // 6: falling edge sets nothing
    switches = 9'h1FD;
    repeat (8) @(posedge clk);
    #1;
    read_now("fall_pg0", 4'd12, 8'h00, 8'hFD);
    read_now("fall_noflag", 4'd14, 8'h00, 8'h00);

    // 5b: rise of bit 1 lands on the same edge as a page-14 clear
    switches = 9'h1FF;
    repeat (5) @(posedge clk);
    #1;
    addr  = 4'd14;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    read_now("set_wins", 4'd14, 8'h00, 8'h02);
    read_now("set_wins_pg0", 4'd12, 8'h00, 8'hFF);
    rd_en = 1'b1;
    addr  = 4'd14;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    read_now("edge14_clr2", 4'd14, 8'h00, 8'h00);
`else
    // Without edge capture, edge addresses pass through and rd_en does nothing
    rd_en = 1'b1;
    read_now("noedge_14", 4'd14, 8'h5A, 8'h5A);
    read_now("noedge_15", 4'd15, 8'hC3, 8'hC3);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    read_now("noedge_pg0", 4'd12, 8'h00, 8'hFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
